// File: rtl/bomb_input_conditioner_pkg.sv
// Shared bomb constants: debounce default and the button FSM state encodings.
package bomb_input_conditioner_pkg;

    // 10 ms at a 50 MHz clock.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } btn_state_t;

endpackage

// File: rtl/bomb_input_conditioner_debounce_cell.sv
// Purpose: 2-flop synchronizer plus stability counter for one raw level input.
// Latency: a stable raw change reaches out_level after edge DEBOUNCE_CYCLES+2.
// Backpressure: none; free-running level path.
module debounce_cell
    import bomb_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic async_nreset,
    input  logic in_raw,
    output logic out_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            sync_q    <= 2'b00;
            cnt       <= '0;
            out_level <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], in_raw};
            // Any sample agreeing with the output restarts the stability window.
            if (sync_q[1] == out_level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                out_level <= sync_q[1];
                cnt       <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bomb_input_conditioner.sv
// Purpose: debounce the start button into a one-cycle pulse and the three switches into levels.
// Latency: pulse after edge DEBOUNCE_CYCLES+3 of a held press; switches after edge DEBOUNCE_CYCLES+2.
// Backpressure: none; outputs are registered and always valid.
module bomb_input_conditioner
    import bomb_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       async_nreset,
    input  logic       key_n,
    input  logic [2:0] sw_raw,
    output logic       start_countdown,
    output logic       sw3,
    output logic       sw2,
    output logic       sw1
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    key_sync;
    logic          pressed;
    btn_state_t    state;
    btn_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          pulse_nxt;

    // Key synchronizer resets to released so a button held through reset is seen as a new press.
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            key_sync <= 2'b11;
        end else begin
            key_sync <= {key_sync[0], key_n};
        end
    end

    assign pressed = ~key_sync[1];

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            state           <= IDLE;
            cnt             <= '0;
            start_countdown <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            start_countdown <= pulse_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (pressed) begin
                    state_nxt = PRESS_CHK;
                    cnt_nxt   = '0;
                end
            end
            PRESS_CHK: begin
                if (!pressed) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_nxt = RELEASE_CHK;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_CHK: begin
                if (pressed) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        pulse_nxt = 1'b0;
        if (state == PRESS_CHK && pressed && cnt == CNT_MAX) begin
            pulse_nxt = 1'b1;
        end
    end

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw1 (
        .clk          (clk),
        .async_nreset (async_nreset),
        .in_raw       (sw_raw[0]),
        .out_level    (sw1)
    );

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw2 (
        .clk          (clk),
        .async_nreset (async_nreset),
        .in_raw       (sw_raw[1]),
        .out_level    (sw2)
    );

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw3 (
        .clk          (clk),
        .async_nreset (async_nreset),
        .in_raw       (sw_raw[2]),
        .out_level    (sw3)
    );

endmodule

// File: tb/tb_bomb_input_conditioner.sv
// Directed and random stimulus for bomb_input_conditioner against a run-length reference model.
module tb_bomb_input_conditioner;

    localparam int D = 4;

    logic       clk;
    logic       async_nreset;
    logic       key_n;
    logic [2:0] sw_raw;
    logic       start_countdown;
    logic       sw3;
    logic       sw2;
    logic       sw1;

    int vectors;
    int miscompares;
    int pulses;

    // Reference model: two-sample input delay, then a level is accepted once the
    // delayed samples disagree with it for enough consecutive edges.
    logic       m_k1, m_k2, m_key_level;
    int         m_key_run;
    logic [2:0] m_s1, m_s2, exp_sw;
    int         m_sw_run [3];
    logic       exp_pulse;

    bomb_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk             (clk),
        .async_nreset    (async_nreset),
        .key_n           (key_n),
        .sw_raw          (sw_raw),
        .start_countdown (start_countdown),
        .sw3             (sw3),
        .sw2             (sw2),
        .sw1             (sw1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_k1        = 1'b1;
        m_k2        = 1'b1;
        m_key_level = 1'b1;
        m_key_run   = 0;
        m_s1        = 3'b000;
        m_s2        = 3'b000;
        exp_sw      = 3'b000;
        exp_pulse   = 1'b0;
        for (int i = 0; i < 3; i++) m_sw_run[i] = 0;
    endtask

    task automatic model_edge();
        logic       k_seen;
        logic [2:0] s_seen;
        if (async_nreset) begin
            k_seen = m_k2;
            m_k2   = m_k1;
            m_k1   = key_n;
            s_seen = m_s2;
            m_s2   = m_s1;
            m_s1   = sw_raw;
            exp_pulse = 1'b0;
            // Button needs D+1 consecutive disagreeing samples (entry edge plus D counted ones).
            if (k_seen == m_key_level) begin
                m_key_run = 0;
            end else begin
                m_key_run++;
                if (m_key_run == D + 1) begin
                    m_key_level = k_seen;
                    m_key_run   = 0;
                    if (!k_seen) exp_pulse = 1'b1;
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (s_seen[i] == exp_sw[i]) begin
                    m_sw_run[i] = 0;
                end else begin
                    m_sw_run[i]++;
                    if (m_sw_run[i] == D) begin
                        exp_sw[i]   = s_seen[i];
                        m_sw_run[i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0b expected %0b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_sw(input string tag, input logic [2:0] exp);
        vectors++;
        assert ({sw3, sw2, sw1} === exp) else begin
            miscompares++;
            $error("FAIL %s: observed sw=%03b expected %03b at %0t", tag, {sw3, sw2, sw1}, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (start_countdown === 1'b1) pulses++;
        check_bit("pulse", start_countdown, exp_pulse);
        check_sw("sw", exp_sw);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Called just after a rising edge: asserts reset mid-cycle, releases on a later falling edge.
    task automatic do_reset();
        #3;
        async_nreset = 1'b0;
        #2;
        model_reset();
        check_bit("rst_pulse", start_countdown, 1'b0);
        check_sw("rst_sw", 3'b000);
        @(negedge clk);
        async_nreset = 1'b1;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        pulses       = 0;
        key_n        = 1'b1;
        sw_raw       = 3'b000;
        async_nreset = 1'b1;
        model_reset();
        #1;
        async_nreset = 1'b0;
        #2;
        check_bit("reset_pulse", start_countdown, 1'b0);
        check_sw("reset_sw", 3'b000);

        // Press held from before edge 1: single pulse right after edge 7.
        key_n = 1'b0;
        @(negedge clk);
        async_nreset = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            check_bit("latency", start_countdown, (e == 7) ? 1'b1 : 1'b0);
        end

        // Release, then five short presses that never qualify.
        key_n = 1'b1;
        ticks(10);
        pulses = 0;
        for (int r = 0; r < 5; r++) begin
            key_n = 1'b0;
            ticks(3);
            key_n = 1'b1;
            ticks(3);
        end
        ticks(6);
        check_bit("glitch_no_pulse", pulses == 0, 1'b1);

        // Accepted press followed by release bounce: exactly one pulse.
        pulses = 0;
        key_n  = 1'b0;
        ticks(10);
        for (int b = 0; b < 5; b++) begin
            key_n = 1'b1;
            ticks(2);
            key_n = 1'b0;
            ticks(2);
        end
        ticks(10);
        check_bit("bounce_one_pulse", pulses == 1, 1'b1);
        key_n = 1'b1;
        ticks(10);

        // Switch 3 rises after edge 6; a 3-cycle dip is filtered.
        sw_raw = 3'b100;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check_bit("sw3_latency", sw3, (e >= 6) ? 1'b1 : 1'b0);
        end
        sw_raw = 3'b000;
        ticks(3);
        sw_raw = 3'b100;
        for (int e = 0; e < 8; e++) begin
            tick();
            check_bit("sw3_hold", sw3, 1'b1);
        end

        // Reset in PRESS_CHK with counter at 2, key held low through release.
        key_n = 1'b0;
        ticks(5);
        do_reset();
        pulses = 0;
        ticks(12);
        check_bit("reset_repress_one_pulse", pulses == 1, 1'b1);
        key_n = 1'b1;
        ticks(10);

        // Switch snapshot visible in the pulse cycle.
        sw_raw = 3'b010;
        ticks(8);
        key_n  = 1'b0;
        pulses = 0;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (start_countdown === 1'b1) check_sw("pulse_sw_snapshot", 3'b010);
        end
        check_bit("snapshot_pulse_seen", pulses == 1, 1'b1);
        key_n = 1'b1;
        ticks(10);

        // Random segments of button levels and switch changes.
        for (int s = 0; s < 120; s++) begin
            int len;
            key_n = 1'($urandom_range(0, 1));
            len   = $urandom_range(1, 9);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 5) == 0) sw_raw = 3'($urandom_range(0, 7));
                tick();
            end
            if ($urandom_range(0, 39) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bomb_input_conditioner.md
BOMB_INPUT_CONDITIONER -- requirements
Module: bomb_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, stable-sample count required to accept a level change; SHALL be >= 2.
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 async_nreset  input  1  reset, asynchronous, active-low.
REQ-004 key_n  input  1  raw push-button, asynchronous, low = pressed.
REQ-005 sw_raw  input  3  raw slide switches, asynchronous; bit2->sw3, bit1->sw2, bit0->sw1.
REQ-006 start_countdown  output  1  registered single-cycle pulse per accepted press; feeds bomb_controller.
REQ-007 sw3, sw2, sw1  output  1 each  registered debounced switch levels; feed bomb_controller.

Function
REQ-008 key_n and each sw_raw bit SHALL pass a 2-flop synchronizer before any other logic.
REQ-009 Button FSM states SHALL be IDLE, PRESS_CHK, HELD, RELEASE_CHK with one shared counter of width clog2(DEBOUNCE_CYCLES).
REQ-010 IDLE: synced pressed -> PRESS_CHK, counter=0; else stay.
REQ-011 PRESS_CHK: synced released -> IDLE; pressed and counter==DEBOUNCE_CYCLES-1 -> HELD and start_countdown=1 next cycle; else counter+1.
REQ-012 HELD: synced released -> RELEASE_CHK, counter=0; else stay; no further pulse while held.
REQ-013 RELEASE_CHK: synced pressed -> HELD (no pulse); released and counter==DEBOUNCE_CYCLES-1 -> IDLE; else counter+1.
REQ-014 Latency: key_n held low from before rising edge 1 SHALL give start_countdown high after edge DEBOUNCE_CYCLES+3, for exactly one cycle.
REQ-015 A press or release glitch shorter than DEBOUNCE_CYCLES synced cycles SHALL produce no pulse and no state advance past the CHK state.
REQ-016 Each switch: counter SHALL clear when synced value equals output; increment while different; when different and counter==DEBOUNCE_CYCLES-1, output takes synced value and counter clears.
REQ-017 Switch latency: a raw change held stable SHALL appear on the output after edge DEBOUNCE_CYCLES+2.
REQ-018 Switch and button paths SHALL be independent; start_countdown and switch updates in the same cycle are allowed; the pulse cycle shows the switch values then registered.
REQ-019 Counters SHALL never wrap; maximum value is DEBOUNCE_CYCLES-1.

Reset
REQ-020 async_nreset low SHALL immediately force: FSM=IDLE, all counters=0, start_countdown=0, sw3/sw2/sw1=0, key synchronizer=1 (released), switch synchronizers=0.
REQ-021 Reset during PRESS_CHK SHALL cancel the pending pulse.
REQ-022 A button held low through reset deassertion SHALL be treated as a new press: exactly one pulse per REQ-014 timing.

Structure
REQ-023 FSM state encodings (2-bit) and the DEBOUNCE_CYCLES default SHALL live in the shared bomb constants include, beside the bomb_controller state encodings.
REQ-024 Per-switch synchronizer+counter SHALL be one sub-module, debounce_cell (parameter DEBOUNCE_CYCLES, ports clk, async_nreset, in_raw, out_level), instantiated three times.
REQ-025 Button path SHALL be inline FSM in bomb_input_conditioner.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 key_n low from before edge 1 and held -> start_countdown high only in the cycle after edge 7; low thereafter while held.
REQ-027 key_n low for 3 cycles, then high, repeated 5 times -> start_countdown never asserts.
REQ-028 After an accepted press, key_n bounces high 2 cycles/low 2 cycles for 20 cycles, then stays low -> no second pulse; FSM returns to HELD.
REQ-029 sw_raw 000->100 held -> sw3=1 after edge 6; 100->000 pulse of 3 cycles -> sw3 remains 1.
REQ-030 async_nreset asserted mid-clock while FSM in PRESS_CHK with counter=2 -> start_countdown=0, sw outputs=0 immediately; no pulse before a fresh 4-cycle-stable press.
REQ-031 sw_raw=010 stable, then key pressed -> pulse cycle shows sw3=0, sw2=1, sw1=0.
